// File: rtl/ddr5_deser_phase_ctrl.sv
// ddr5_deser_phase_ctrl
//   Read-burst sequencer feeding the per-lane deserializers of one channel.
//   A start request optionally waits a programmable pre-delay, then emits one
//   capture beat per clock while cycling phase slots 0..3. Back-to-back bursts
//   are chained without a gap when the new request lands on the last beat.
//
// Ports
//   clk_i         block clock
//   rst_i         synchronous, active-high reset
//   start_i       one-cycle burst request
//   burst_len_i   beats in the burst (4, 8, 12 or 16), sampled with start_i
//   pre_delay_i   idle cycles before the first beat, sampled with start_i
//   enable_o      capture strobe
//   phase_sel_o   phase slot of the current beat
//   count_done_o  high on the beat with phase slot 3
//   busy_o        high while waiting or capturing
//   burst_done_o  one-cycle pulse on the last beat of a burst
//   err_o         one-cycle pulse when a start request is rejected
//
// State table
//   IDLE    | no burst in progress; accepts start_i
//   WAIT    | counting down the pre-delay; enable_o held low
//   CAPTURE | emitting beats; start_i accepted only on the last beat
module ddr5_deser_phase_ctrl #(
  parameter int DLY_W = 4,
  parameter int BL_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BL_W-1:0]  burst_len_i,
  input  logic [DLY_W-1:0] pre_delay_i,
  output logic             enable_o,
  output logic [1:0]       phase_sel_o,
  output logic             count_done_o,
  output logic             busy_o,
  output logic             burst_done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  state_t           state_q, state_n;
  logic [BL_W-1:0]  len_q, len_n;
  logic [BL_W-1:0]  beat_q, beat_n;   // beats already presented in this burst
  logic [DLY_W-1:0] wait_q, wait_n;

  logic             en_n, cd_n, bd_n, busy_n, err_n;
  logic [1:0]       ph_n, ph_inc;
  logic [BL_W-1:0]  beat_inc;
  logic             len_ok, last_beat, take_start;

  always_comb begin
    state_n  = state_q;
    len_n    = len_q;
    beat_n   = beat_q;
    wait_n   = wait_q;
    en_n     = 1'b0;
    ph_n     = 2'd0;
    cd_n     = 1'b0;
    bd_n     = 1'b0;
    busy_n   = 1'b0;
    err_n    = 1'b0;

    len_ok     = (burst_len_i[1:0] == 2'b00) && (burst_len_i != '0) &&
                 (32'(burst_len_i) <= 32'd16);
    last_beat  = (state_q == CAPTURE) && (beat_q == len_q);
    take_start = start_i && len_ok && ((state_q == IDLE) || last_beat);
    ph_inc     = phase_sel_o + 2'd1;
    beat_inc   = beat_q + BL_W'(1);

    case (state_q)
      WAIT: begin
        busy_n = 1'b1;
        // Counter was loaded with dly >= 1, so reaching 1 means the next
        // cycle is the first beat.
        if (wait_q == DLY_W'(1)) begin
          state_n = CAPTURE;
          en_n    = 1'b1;
          beat_n  = BL_W'(1);
        end else begin
          wait_n = wait_q - DLY_W'(1);
        end
      end
      CAPTURE: begin
        if (!last_beat) begin
          busy_n = 1'b1;
          en_n   = 1'b1;
          ph_n   = ph_inc;
          beat_n = beat_inc;
          cd_n   = (ph_inc == 2'd3);
          bd_n   = (beat_inc == len_q);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // An accepted start overrides whatever the current state planned; a
    // rejected one only raises err_o and leaves the burst untouched.
    if (start_i) begin
      if (take_start) begin
        len_n  = burst_len_i;
        busy_n = 1'b1;
        ph_n   = 2'd0;
        cd_n   = 1'b0;
        bd_n   = 1'b0;
        if (pre_delay_i == '0) begin
          state_n = CAPTURE;
          en_n    = 1'b1;
          beat_n  = BL_W'(1);
        end else begin
          state_n = WAIT;
          en_n    = 1'b0;
          beat_n  = '0;
          wait_n  = pre_delay_i;
        end
      end else begin
        err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      beat_q       <= '0;
      wait_q       <= '0;
      enable_o     <= 1'b0;
      phase_sel_o  <= 2'd0;
      count_done_o <= 1'b0;
      busy_o       <= 1'b0;
      burst_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_n;
      len_q        <= len_n;
      beat_q       <= beat_n;
      wait_q       <= wait_n;
      enable_o     <= en_n;
      phase_sel_o  <= ph_n;
      count_done_o <= cd_n;
      busy_o       <= busy_n;
      burst_done_o <= bd_n;
      err_o        <= err_n;
    end
  end

endmodule

// File: tb/tb_ddr5_deser_phase_ctrl.sv
// Testbench for ddr5_deser_phase_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a timeline model.
module tb_ddr5_deser_phase_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [4:0] burst_len_i = '0;
  logic [3:0] pre_delay_i = '0;
  logic       enable_o, count_done_o, busy_o, burst_done_o, err_o;
  logic [1:0] phase_sel_o;

  ddr5_deser_phase_ctrl #(.DLY_W(4), .BL_W(5)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .burst_len_i  (burst_len_i),
    .pre_delay_i  (pre_delay_i),
    .enable_o     (enable_o),
    .phase_sel_o  (phase_sel_o),
    .count_done_o (count_done_o),
    .busy_o       (busy_o),
    .burst_done_o (burst_done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Timeline model: a burst is described by the cycle of its first beat and
  // of its last beat. Cycle n is the clock period following edge n-1.
  int cyc        = 0;
  int first_beat = 0;
  int last_beat  = -1;
  int err_cyc    = -1;
  int bd_count   = 0;
  int en_count   = 0;
  logic [6:0] act;

  function automatic bit legal_len(input int len);
    return (len % 4 == 0) && (len >= 4) && (len <= 16);
  endfunction

  task automatic model_edge(input int t, input logic rst, input logic start,
                            input int len, input int dly);
    if (rst) begin
      last_beat = -1;
      err_cyc   = -1;
    end else if (start) begin
      if (legal_len(len) && t >= last_beat) begin
        first_beat = t + 1 + dly;
        last_beat  = first_beat + len - 1;
      end else begin
        err_cyc = t + 1;
      end
    end
  endtask

  // Packed as {enable, phase[1:0], count_done, burst_done, busy, err}
  function automatic logic [6:0] model_out(input int n);
    logic       en, cd, bd, busy, er;
    logic [1:0] ph;
    en = 0; cd = 0; bd = 0; busy = 0; ph = 0;
    er = (n == err_cyc);
    if (n <= last_beat) begin
      busy = 1;
      if (n >= first_beat) begin
        en = 1;
        ph = 2'((n - first_beat) % 4);
        cd = (ph == 2'd3);
        bd = (n == last_beat);
      end
    end
    return {en, ph, cd, bd, busy, er};
  endfunction

  task automatic step(input logic rst, input logic start, input int len, input int dly);
    logic [6:0] exp;
    rst_i       = rst;
    start_i     = start;
    burst_len_i = 5'(len);
    pre_delay_i = 4'(dly);
    @(posedge clk_i);
    model_edge(cyc, rst, start, len, dly);
    cyc++;
    @(negedge clk_i);
    act = {enable_o, phase_sel_o, count_done_o, burst_done_o, busy_o, err_o};
    exp = model_out(cyc);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model cyc=%0d got=%b expected=%b", cyc, act, exp);
    end
    bd_count += int'(burst_done_o);
    en_count += int'(enable_o);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  typedef struct {
    logic       start;
    logic [4:0] len;
    logic [3:0] dly;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // len=8 dly=0 burst, then an illegal len=6 request from IDLE
    tbl[0]  = '{1'b1, 5'd8, 4'd0, 7'b1_00_0_0_1_0};
    tbl[1]  = '{1'b0, 5'd0, 4'd0, 7'b1_01_0_0_1_0};
    tbl[2]  = '{1'b0, 5'd0, 4'd0, 7'b1_10_0_0_1_0};
    tbl[3]  = '{1'b0, 5'd0, 4'd0, 7'b1_11_1_0_1_0};
    tbl[4]  = '{1'b0, 5'd0, 4'd0, 7'b1_00_0_0_1_0};
    tbl[5]  = '{1'b0, 5'd0, 4'd0, 7'b1_01_0_0_1_0};
    tbl[6]  = '{1'b0, 5'd0, 4'd0, 7'b1_10_0_0_1_0};
    tbl[7]  = '{1'b0, 5'd0, 4'd0, 7'b1_11_1_1_1_0};
    tbl[8]  = '{1'b0, 5'd0, 4'd0, 7'b0_00_0_0_0_0};
    tbl[9]  = '{1'b1, 5'd6, 4'd0, 7'b0_00_0_0_0_1};
    tbl[10] = '{1'b0, 5'd0, 4'd0, 7'b0_00_0_0_0_0};

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("reset_outputs", int'(act), 0);

    for (int i = 0; i < 11; i++) begin
      step(0, tbl[i].start, int'(tbl[i].len), int'(tbl[i].dly));
      n_checks++;
      if (act !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL vec[%0d] got=%b expected=%b", i, act, tbl[i].exp);
      end
    end

    // len=16, dly=3: three waiting cycles, then sixteen beats
    bd_count = 0; en_count = 0;
    step(0, 1, 16, 3);
    check("dly3_busy_first", int'(busy_o), 1);
    check("dly3_enable_first", int'(enable_o), 0);
    for (int k = 1; k < 19; k++) step(0, 0, 0, 0);
    check("dly3_last_done", int'(burst_done_o), 1);
    check("dly3_enable_count", en_count, 16);
    step(0, 0, 0, 0);

    // back-to-back len=4 bursts, second request on the last beat
    bd_count = 0; en_count = 0;
    step(0, 1, 4, 0);
    for (int k = 1; k < 4; k++) step(0, 0, 0, 0);
    step(0, 1, 4, 0);
    check("b2b_phase_restart", int'(phase_sel_o), 0);
    check("b2b_enable_gapless", int'(enable_o), 1);
    for (int k = 5; k < 8; k++) step(0, 0, 0, 0);
    check("b2b_enable_count", en_count, 8);
    check("b2b_done_pulses", bd_count, 2);
    step(0, 0, 0, 0);

    // collision inside an 8-beat burst
    bd_count = 0;
    step(0, 1, 8, 0);
    step(0, 0, 0, 0);
    step(0, 1, 8, 0);
    check("collide_err", int'(err_o), 1);
    for (int k = 3; k < 8; k++) step(0, 0, 0, 0);
    check("collide_done", int'(burst_done_o), 1);
    check("collide_done_count", bd_count, 1);
    step(0, 0, 0, 0);

    // reset held two cycles mid-capture abandons the burst
    step(0, 1, 16, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 8, 0);
    check("midreset_outputs", int'(act), 0);
    bd_count = 0;
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
    check("midreset_no_done", bd_count, 0);

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      logic r, s;
      int   len, dly;
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 3) == 0);
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31))
                                        : 4 * int'($urandom_range(1, 4));
      dly = ($urandom_range(0, 1) == 0) ? 0
          : (($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(1, 4)));
      step(r, s, len, dly);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
